// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word memory, with fixed wait states and out-of-range error response.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  Pclk,
  input  logic                  Prst,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         addr_q, addr_d;
  logic                  write_q, write_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  setup, in_err, commit;
  assign setup   = state_q == IDLE && Psel && !Penable;
  assign in_err  = {1'b0, Paddr} >= DEPTH_L;
  assign Pready  = state_q == ACCESS && cnt_q == 4'd0 && Psel && Penable;
  assign Pslverr = Pready && err_q;
  assign Prdata  = rdata_q;
  // a completion coinciding with reset must not reach memory
  assign commit  = Pready && write_q && !err_q && !Prst;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (setup) begin
      state_d = ACCESS;
      addr_d  = Paddr[IW-1:0];
      write_d = Pwrite;
      wdata_d = Pwdata;
      err_d   = in_err;
      cnt_d   = WAIT_CYCLES[3:0];
      rdata_d = (!Pwrite && !in_err) ? mem[Paddr[IW-1:0]] : '0;
    end else if (state_q == ACCESS) begin
      if (!Psel) state_d = IDLE;
      else if (Penable) begin
        cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
        state_d = Pready ? IDLE : ACCESS;
      end
    end
  end
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge Pclk) begin
    if (commit) mem[addr_q] <= wdata_q;
  end
endmodule
